// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported, fixed-latency main memory.
// Port 0 is the multi-cycle core, port 1 a DMA/debug master. One transaction
// is in flight at a time; grants alternate round-robin when both ports ask.
module mem_port_arbiter #(
    parameter int RD_LATENCY = 3,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_read_data
);

    // Read-wait counter is at least 2 bits wide so small latencies still fit.
    localparam int CNT_W = ($clog2(RD_LATENCY) < 2) ? 2 : $clog2(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR,
        WR_REC
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             owner;       // port that owns the transaction in flight
    logic             last_owner;  // port granted most recently
    logic             any_req;
    logic             winner;
    logic             win_we;
    logic             grant;

    // Round-robin winner: a lone requester wins, otherwise the port not served last.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            winner = ~last_owner;
        end else begin
            winner = m1_req;
        end
        win_we = winner ? m1_we : m0_we;
        // No grant can be issued while reset is being applied.
        grant  = (state == IDLE) && any_req && !reset;
    end

    // Next-state decode, memory strobes, grant and completion pulses.
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        m0_done    = 1'b0;
        m1_done    = 1'b0;
        m0_gnt     = grant && !winner;
        m1_gnt     = grant && winner;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = win_we ? WR : RD_WAIT;
                end
            end
            RD_WAIT: begin
                mem_read = 1'b1;
                if (cnt == '0) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                // A reset landing on the completion cycle discards the transaction.
                m0_done    = !reset && !owner;
                m1_done    = !reset && owner;
                state_next = IDLE;
            end
            WR: begin
                mem_write  = 1'b1;
                state_next = WR_REC;
            end
            WR_REC: begin
                m0_done    = !reset && !owner;
                m1_done    = !reset && owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ownership tracking and read-latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;   // so port 0 wins the first contested grant
        end else if (grant) begin
            cnt        <= CNT_LOAD;
            owner      <= winner;
            last_owner <= winner;
        end else if (state == RD_WAIT && cnt != '0) begin
            cnt        <= cnt - CNT_W'(1);
        end
    end

    // Memory address/data latch on grant; read data captured on the last wait cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr       <= '0;
            mem_write_data <= '0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
        end else begin
            if (grant) begin
                mem_addr       <= winner ? m1_addr  : m0_addr;
                mem_write_data <= winner ? m1_wdata : m0_wdata;
            end
            if (state == RD_WAIT && cnt == '0) begin
                if (owner) begin
                    m1_rdata <= mem_read_data;
                end else begin
                    m0_rdata <= mem_read_data;
                end
            end
        end
    end

endmodule
